// File: rtl/lea_pkg.sv
// Shared definitions for the LEA-128 round scheduler.
//   LEA_ROUNDS : default round count (round-key RAM depth)
//   LEA_CNT_W  : default round index / address width
//   state_e    : scheduler FSM states
//   ENC / DEC  : values of the decrypt mode bit
package lea_pkg;

   localparam int LEA_ROUNDS = 24;
   localparam int LEA_CNT_W  = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYGEN = 3'd1,
      LOAD   = 3'd2,
      ROUND  = 3'd3,
      OUT    = 3'd4
   } state_e;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

endpackage

// File: rtl/lea_round_sched_if.sv
// Bus between the LEA control unit / datapath and the round scheduler.
//   master : control side, drives start/decrypt/key_new, observes the rest
//   slave  : the scheduler, drives status and datapath strobes
interface lea_round_sched_if
   import lea_pkg::*;
#(
   parameter int CNT_W = LEA_CNT_W
);

   logic             start;
   logic             decrypt;
   logic             key_new;
   logic             busy;
   logic             done;
   logic             rk_ready;
   logic             ks_load;
   logic             ks_en;
   logic             rk_we;
   logic [CNT_W-1:0] rk_addr;
   logic             rnd_load;
   logic             rnd_en;
   logic             rnd_dec;
   logic [CNT_W-1:0] rnd_idx;
   logic             out_we;

   modport master (
      output start, decrypt, key_new,
      input  busy, done, rk_ready, ks_load, ks_en, rk_we, rk_addr,
             rnd_load, rnd_en, rnd_dec, rnd_idx, out_we
   );

   modport slave (
      input  start, decrypt, key_new,
      output busy, done, rk_ready, ks_load, ks_en, rk_we, rk_addr,
             rnd_load, rnd_en, rnd_dec, rnd_idx, out_we
   );

endinterface

// File: rtl/lea_rnd_cnt.sv
// Loadable up/down round counter with saturating terminal flag.
//   clk, rst     : clock, synchronous active-high reset (count -> 0)
//   clr_i        : force count to 0
//   load_i       : load load_val_i (lower priority than clr_i)
//   en_i, up_i   : step by one in the chosen direction
//   cnt_o        : registered count
//   tc_o         : count is at ROUNDS-1 (up) or 0 (down); stepping holds there
module lea_rnd_cnt #(
   parameter int CNT_W  = 5,
   parameter int ROUNDS = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tc_o  = up_i ? (cnt_q == LAST) : (cnt_q == '0);
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (en_i && !tc_o)
         cnt_d = up_i ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lea_round_sched.sv
// LEA-128 round scheduler: rebuilds the round-key RAM when the key changes,
// then sequences LOAD / ROUND x ROUNDS / OUT for one request at a time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of lea_round_sched_if (request in, strobes out)
//
//   state  | meaning
//   IDLE   | waiting for start; key_new clears rk_ready
//   KEYGEN | cycle 0 ks_load, then ROUNDS cycles writing round keys
//   LOAD   | load cipher state, first round key being read
//   ROUND  | one round per cycle, next key prefetched on rk_addr
//   OUT    | capture result, pulse done
module lea_round_sched
   import lea_pkg::*;
#(
   parameter int ROUNDS = LEA_ROUNDS,
   parameter int CNT_W  = LEA_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   lea_round_sched_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

   state_e state_q, state_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   rk_ready_q, rk_ready_d;
   logic   stale_q, stale_d;
   logic   ks_load_q, ks_load_d;
   logic   ks_en_q, ks_en_d;
   logic   rk_we_q, rk_we_d;
   logic   rnd_load_q, rnd_load_d;
   logic   rnd_en_q, rnd_en_d;
   logic   rnd_dec_q, rnd_dec_d;
   logic   out_we_q, out_we_d;

   logic             addr_clr, addr_load, addr_en, addr_up, addr_tc;
   logic [CNT_W-1:0] addr_val, addr_cnt;
   logic             idx_clr, idx_load, idx_en, idx_tc;
   logic [CNT_W-1:0] idx_val, idx_cnt;

   // Key writes always ascend; reads follow the latched mode.
   assign addr_up = (state_q == KEYGEN) || (rnd_dec_q == ENC);

   lea_rnd_cnt #(.CNT_W(CNT_W), .ROUNDS(ROUNDS)) u_addr (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (addr_clr),
      .load_i     (addr_load),
      .load_val_i (addr_val),
      .en_i       (addr_en),
      .up_i       (addr_up),
      .cnt_o      (addr_cnt),
      .tc_o       (addr_tc)
   );

   // Counts the applied round index directly (up for enc, down for dec).
   lea_rnd_cnt #(.CNT_W(CNT_W), .ROUNDS(ROUNDS)) u_idx (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (idx_clr),
      .load_i     (idx_load),
      .load_val_i (idx_val),
      .en_i       (idx_en),
      .up_i       (rnd_dec_q == ENC),
      .cnt_o      (idx_cnt),
      .tc_o       (idx_tc)
   );

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      ks_load_d  = 1'b0;
      ks_en_d    = 1'b0;
      rk_we_d    = 1'b0;
      rnd_load_d = 1'b0;
      rnd_en_d   = 1'b0;
      out_we_d   = 1'b0;
      rk_ready_d = rk_ready_q;
      stale_d    = stale_q;
      rnd_dec_d  = rnd_dec_q;
      addr_clr   = 1'b0;
      addr_load  = 1'b0;
      addr_val   = '0;
      addr_en    = 1'b0;
      idx_clr    = 1'b0;
      idx_load   = 1'b0;
      idx_val    = '0;
      idx_en     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) rnd_dec_d = bus.decrypt;
            if (bus.key_new) rk_ready_d = 1'b0;
            // key_new in the same cycle as start invalidates the schedule
            if (bus.start && (bus.key_new || !rk_ready_q)) begin
               state_d   = KEYGEN;
               ks_load_d = 1'b1;
               addr_clr  = 1'b1;
            end else if (bus.start) begin
               state_d    = LOAD;
               rnd_load_d = 1'b1;
               addr_load  = 1'b1;
               addr_val   = (bus.decrypt == DEC) ? LAST : '0;
            end
         end
         KEYGEN: begin
            if (bus.key_new) begin
               ks_load_d = 1'b1;
               addr_clr  = 1'b1;
            end else if (ks_load_q) begin
               // first write cycle keeps rk_addr at 0
               ks_en_d = 1'b1;
               rk_we_d = 1'b1;
            end else if (addr_tc) begin
               state_d    = LOAD;
               rk_ready_d = 1'b1;
               rnd_load_d = 1'b1;
               addr_load  = 1'b1;
               addr_val   = (rnd_dec_q == DEC) ? LAST : '0;
            end else begin
               ks_en_d = 1'b1;
               rk_we_d = 1'b1;
               addr_en = 1'b1;
            end
         end
         LOAD: begin
            if (bus.key_new) stale_d = 1'b1;
            state_d  = ROUND;
            rnd_en_d = 1'b1;
            idx_load = 1'b1;
            idx_val  = (rnd_dec_q == DEC) ? LAST : '0;
            addr_en  = 1'b1;
         end
         ROUND: begin
            if (bus.key_new) stale_d = 1'b1;
            if (idx_tc) begin
               state_d  = OUT;
               out_we_d = 1'b1;
               done_d   = 1'b1;
               idx_clr  = 1'b1;
               addr_clr = 1'b1;
            end else begin
               rnd_en_d = 1'b1;
               idx_en   = 1'b1;
               addr_en  = 1'b1;  // saturates on the last step
            end
         end
         OUT: begin
            state_d = IDLE;
            if (stale_q || bus.key_new) rk_ready_d = 1'b0;
            stale_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rk_ready_q <= 1'b0;
         stale_q    <= 1'b0;
         ks_load_q  <= 1'b0;
         ks_en_q    <= 1'b0;
         rk_we_q    <= 1'b0;
         rnd_load_q <= 1'b0;
         rnd_en_q   <= 1'b0;
         rnd_dec_q  <= 1'b0;
         out_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rk_ready_q <= rk_ready_d;
         stale_q    <= stale_d;
         ks_load_q  <= ks_load_d;
         ks_en_q    <= ks_en_d;
         rk_we_q    <= rk_we_d;
         rnd_load_q <= rnd_load_d;
         rnd_en_q   <= rnd_en_d;
         rnd_dec_q  <= rnd_dec_d;
         out_we_q   <= out_we_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rk_ready = rk_ready_q;
   assign bus.ks_load  = ks_load_q;
   assign bus.ks_en    = ks_en_q;
   assign bus.rk_we    = rk_we_q;
   assign bus.rk_addr  = addr_cnt;
   assign bus.rnd_load = rnd_load_q;
   assign bus.rnd_en   = rnd_en_q;
   assign bus.rnd_dec  = rnd_dec_q;
   assign bus.rnd_idx  = idx_cnt;
   assign bus.out_we   = out_we_q;

endmodule

// File: tb/tb_lea_round_sched.sv
// Self-checking bench for lea_round_sched: a table of back-to-back requests
// checked cycle by cycle against a timeline model, plus hand sequences for
// key_new during KEYGEN/ROUND, start while busy and reset mid-operation.
module tb_lea_round_sched;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rk_ready;
      logic       ks_load;
      logic       ks_en;
      logic       rk_we;
      logic [4:0] rk_addr;
      logic       rnd_load;
      logic       rnd_en;
      logic       rnd_dec;
      logic [4:0] rnd_idx;
      logic       out_we;
   } outs_t;

   typedef struct {
      logic dec;
      logic kn;      // key_new together with start
      logic exp_kg;  // request must go through KEYGEN
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   lea_round_sched_if #(.CNT_W(5)) bus ();

   lea_round_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic outs_t sample();
      outs_t s;
      s.busy     = bus.busy;
      s.done     = bus.done;
      s.rk_ready = bus.rk_ready;
      s.ks_load  = bus.ks_load;
      s.ks_en    = bus.ks_en;
      s.rk_we    = bus.rk_we;
      s.rk_addr  = bus.rk_addr;
      s.rnd_load = bus.rnd_load;
      s.rnd_en   = bus.rnd_en;
      s.rnd_dec  = bus.rnd_dec;
      s.rnd_idx  = bus.rnd_idx;
      s.out_we   = bus.out_we;
      return s;
   endfunction

   // Expected outputs k cycles after the edge that sampled start.
   function automatic outs_t exp_at(int k, bit kg, bit dec);
      outs_t e;
      int    off;
      int    i;
      e   = '0;
      off = kg ? 25 : 0;
      e.rnd_dec  = dec;
      e.busy     = (k <= off + 26);
      e.rk_ready = !(kg && k <= off);
      if (kg && k == 1) begin
         e.ks_load = 1'b1;
      end else if (kg && k <= off) begin
         e.ks_en   = 1'b1;
         e.rk_we   = 1'b1;
         e.rk_addr = 5'(k - 2);
      end else if (k == off + 1) begin
         e.rnd_load = 1'b1;
         e.rk_addr  = dec ? 5'd23 : 5'd0;
      end else if (k <= off + 25) begin
         i = k - off - 2;
         e.rnd_en  = 1'b1;
         e.rnd_idx = dec ? 5'(23 - i) : 5'(i);
         if (dec) e.rk_addr = (i >= 22) ? 5'd0 : 5'(22 - i);
         else     e.rk_addr = (i >= 23) ? 5'd23 : 5'(i + 1);
      end else if (k == off + 26) begin
         e.out_we = 1'b1;
         e.done   = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string name, input outs_t act, input outs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Steps until done is seen; returns its cycle (-1 on timeout) and the
   // number of rk_we cycles seen after cyc0.
   task automatic wait_done(input int cyc0, output int dcyc, output int wr);
      int cyc;
      cyc = cyc0;
      wr  = 0;
      while (bus.done !== 1'b1 && cyc < cyc0 + 80) begin
         step();
         cyc++;
         if (bus.rk_we === 1'b1) wr++;
      end
      dcyc = (bus.done === 1'b1) ? cyc : -1;
   endtask

   op_t ops[5];

   initial begin
      outs_t act, e;
      int    off, dcyc, wr, ndone;

      ops[0] = '{dec: 1'b0, kn: 1'b0, exp_kg: 1'b1};  // first request after reset
      ops[1] = '{dec: 1'b1, kn: 1'b0, exp_kg: 1'b0};
      ops[2] = '{dec: 1'b0, kn: 1'b0, exp_kg: 1'b0};
      ops[3] = '{dec: 1'b1, kn: 1'b1, exp_kg: 1'b1};  // start + key_new with rk_ready=1
      ops[4] = '{dec: 1'b0, kn: 1'b0, exp_kg: 1'b0};

      bus.start   = 1'b0;
      bus.decrypt = 1'b0;
      bus.key_new = 1'b0;
      repeat (3) step();
      chk("reset_hold", sample(), outs_t'('0));
      rst = 1'b0;
      step();
      chk("idle_after_reset", sample(), outs_t'('0));

      // back-to-back table: each start is issued in the IDLE cycle after done
      for (int n = 0; n < 5; n++) begin
         off = ops[n].exp_kg ? 25 : 0;
         bus.start   = 1'b1;
         bus.decrypt = ops[n].dec;
         bus.key_new = ops[n].kn;
         for (int k = 1; k <= off + 27; k++) begin
            step();
            bus.start   = 1'b0;
            bus.decrypt = 1'b0;
            bus.key_new = 1'b0;
            act = sample();
            e   = exp_at(k, ops[n].exp_kg, ops[n].dec);
            if (!(k >= off + 2 && k <= off + 25) && k != off + 27) act.rnd_idx = e.rnd_idx;
            if ((ops[n].exp_kg && k == 1) || k == off + 26) act.rk_addr = e.rk_addr;
            if (k == off + 27) act.rnd_dec = e.rnd_dec;
            chk($sformatf("op%0d_cyc%0d", n, k), act, e);
         end
      end

      // key_new restarts KEYGEN at cycle 10
      bus.key_new = 1'b1;
      step();
      bus.key_new = 1'b0;
      chk_int("kn_idle_clears_ready", bus.rk_ready, 0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk_int("kg_restart_ksload1", bus.ks_load, 1);
      repeat (10) step();
      chk_int("kg_c10_addr", {bus.rk_we, bus.rk_addr}, {1'b1, 5'd9});
      bus.key_new = 1'b1;
      step();
      bus.key_new = 1'b0;
      chk_int("kg_restart_ksload", {bus.ks_load, bus.rk_we, bus.rk_addr}, {1'b1, 1'b0, 5'd0});
      wait_done(12, dcyc, wr);
      chk_int("kg_restart_done_cyc", dcyc, 62);
      chk_int("kg_restart_writes", wr + 1, 25);
      step();
      chk_int("kg_restart_ready", {bus.busy, bus.rk_ready}, {1'b0, 1'b1});

      // key_new at ROUND step 5 completes, then forces a new KEYGEN
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (6) step();
      chk_int("rnd5_idx", {bus.rnd_en, bus.rnd_idx}, {1'b1, 5'd5});
      bus.key_new = 1'b1;
      step();
      bus.key_new = 1'b0;
      wait_done(8, dcyc, wr);
      chk_int("rnd5_done_cyc", dcyc, 26);
      chk_int("rnd5_ready_in_out", bus.rk_ready, 1);
      step();
      chk_int("rnd5_idle_ready", {bus.busy, bus.rk_ready}, {1'b0, 1'b0});
      bus.start   = 1'b1;
      bus.decrypt = 1'b1;
      step();
      bus.start   = 1'b0;
      bus.decrypt = 1'b0;
      chk_int("rnd5_next_keygen", {bus.ks_load, bus.rnd_dec}, {1'b1, 1'b1});
      wait_done(1, dcyc, wr);
      chk_int("rnd5_next_done_cyc", dcyc, 51);
      step();

      // start pulses while busy are ignored
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      ndone = 0;
      dcyc  = -1;
      for (int k = 1; k <= 40; k++) begin
         if (bus.done === 1'b1) begin
            ndone++;
            dcyc = k;
         end
         bus.start = (k == 3 || k == 10 || k == 26);
         step();
      end
      bus.start = 1'b0;
      chk_int("busy_start_ndone", ndone, 1);
      chk_int("busy_start_done_cyc", dcyc, 26);
      chk_int("busy_start_idle", bus.busy, 0);

      // reset at ROUND step 12 aborts without done
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (13) step();
      chk_int("rst12_idx", {bus.rnd_en, bus.rnd_idx}, {1'b1, 5'd12});
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst12_outputs", sample(), outs_t'('0));
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      end
      chk_int("rst12_no_done", ndone, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
